// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ        = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Input/output handshake bundle between the converter and its producer/consumer.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    // Both channels: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready and data is held while valid is high.
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [DIGITS-1:0]     out_blank;
    logic                  busy;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_blank, busy
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_blank, busy
    );

endinterface

// File: rtl/bin2bcd_seq_dabble_digit.sv
// One double-dabble correction stage: add 3 to a BCD digit that is 5 or more.
module dabble_digit
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    // d <= 9 in a valid working digit, so the result is at most 12 and fits.
    assign q = (d >= BCD_ADJ_THRESH) ? bcd_digit_t'(d + BCD_ADJ) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Optional leading-zero blank flags built when LEADING_ZERO_BLANK_EN is defined.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    bin2bcd_seq_if.slave        bus,
    output state_t              dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int CAT_W = 4 * DIGITS + WIDTH;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [WIDTH-1:0]      shreg_q;
    logic [4*DIGITS-1:0]   work_q;
    logic [4*DIGITS-1:0]   work_adj;
    logic [CAT_W-1:0]      cat_shift;
    logic [4*DIGITS-1:0]   out_bcd_q;
    logic [DIGITS-1:0]     out_blank_q;
    logic [DIGITS-1:0]     blank_nxt;
    logic                  last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        dabble_digit u_dabble (
            .d (work_q[4*g +: 4]),
            .q (work_adj[4*g +: 4])
        );
    end

    // Corrected digits and remaining binary bits move left together as one word.
    assign cat_shift  = {work_adj, shreg_q} << 1;
    assign last_shift = (cnt_q == CW'(1));

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;
    always_comb begin
        zero_above = 1'b1;
        blank_nxt  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (cat_shift[WIDTH + 4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end
`else
    assign blank_nxt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SHIFT;
            SHIFT:   if (last_shift)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            work_q      <= '0;
            out_bcd_q   <= '0;
            out_blank_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg_q <= bus.in_bin;
                        work_q  <= '0;
                        cnt_q   <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    shreg_q <= cat_shift[WIDTH-1:0];
                    work_q  <= cat_shift[CAT_W-1:WIDTH];
                    cnt_q   <= cnt_q - CW'(1);
                    if (last_shift) begin
                        out_bcd_q   <= cat_shift[CAT_W-1:WIDTH];
                        out_blank_q <= blank_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_blank = out_blank_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (double-dabble) between the 4x4 multiplier product and the three-digit seven-segment decoder. Accepts one unsigned binary word per valid/ready handshake, shifts it through BCD digit registers over WIDTH cycles, and presents packed BCD digits plus optional leading-zero blank flags. Replaces divide/modulo digit extraction, so no combinational dividers remain on the display path.

## Interface
- WIDTH, 8: binary input width; legal only if 10^DIGITS > 2^WIDTH - 1.
- DIGITS, 3: number of BCD output digits.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  in_bin is valid.
- in_ready  out  1  converter can accept; high only in IDLE.
- in_bin  in  WIDTH  unsigned binary value.
- out_valid  out  1  out_bcd/out_blank hold a finished result.
- out_ready  in  1  consumer accepts the result.
- out_bcd  out  4*DIGITS  packed BCD; digit i at [4i+3:4i], digit 0 = units.
- out_blank  out  DIGITS  per-digit blank flag (see Configuration).
- busy  out  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid: load in_bin into the shift register, clear BCD working digits, load the counter with WIDTH, go to SHIFT.
- SHIFT: each cycle, add 3 to every working digit >= 5, then shift {digits, shift register} left by one bit; decrement the counter. On the cycle the counter reaches 0 (WIDTH shifts done), copy working digits to out_bcd and out_blank, go to DONE.
- DONE: out_valid=1. On out_ready, return to IDLE. out_bcd/out_blank stay stable until the next DONE entry, including across the handshake.
- No new input is accepted in SHIFT or DONE. in_valid is ignored outside IDLE.
- Arithmetic: each digit is 4 bits; the add-3 result is always <= 12 before the shift, so it never overflows. Counter width is $clog2(WIDTH+1).
- Reset (any state, including mid-SHIFT): state=IDLE, out_valid=0, out_bcd=0, out_blank=0, busy=0, working registers=0. in_ready=1 once in IDLE. A partial conversion is discarded.

## Timing
- Acceptance edge k (in_valid & in_ready). SHIFT occupies cycles k+1..k+WIDTH. out_valid rises after edge k+WIDTH, so latency = WIDTH cycles (8 at default).
- Result handshake completes on an edge with out_valid & out_ready. in_ready rises the following cycle.
- Minimum period per conversion: WIDTH+2 cycles.
- in_ready, out_valid and busy decode directly from state registers. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- LEADING_ZERO_BLANK_EN defined: out_blank[i]=1 for i>=1 when digit i and all higher digits are 0. out_blank[0] is always 0, so a value of 0 shows a single "0". The flags are registered together with out_bcd.
- Undefined: out_blank is held at all zeros and the blanking logic is not built. The port remains present.

## Structure
- Package bin2bcd_pkg: state enum (IDLE, SHIFT, DONE), bcd_digit_t (logic [3:0]), constant BCD_ADJ_THRESH=5, constant BCD_ADJ=3.
- Sub-module dabble_digit: combinational per-digit add-3-if-≥5, instantiated DIGITS times by generate.
- The downstream segment decoder consumes out_bcd and selects its blank pattern when out_blank[i] is set.

## Test plan
- in_bin=0, out_ready=1 -> out_bcd=0x000. With macro, out_blank=3'b110; without, 3'b000.
- in_bin=225 (15*15) -> out_bcd=0x225, out_valid exactly 8 cycles after acceptance, out_blank=3'b000.
- in_bin=255 then in_bin=7, in_valid held high -> 0x255 then 0x007. With macro, the second gives out_blank=3'b110. in_ready is low between the two conversions.
- Back-pressure: result 0x099 with out_ready low for 5 cycles -> out_valid, out_bcd and out_blank stable, in_ready=0, busy=1. Drop to IDLE one cycle after out_ready rises.
- rst_n pulsed low at SHIFT cycle 4 of in_bin=200 -> all outputs at reset values asynchronously. A following in_bin=100 yields 0x100 (blank 3'b000).
- Exhaustive sweep 0..255 against a reference model -> every digit matches value/10^i mod 10.
